// File: rtl/alu_share_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_share_ctrl_if
//  Description : Request, shared-ALU and response signals of alu_share_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_share_ctrl_if #(
    parameter int W = 32
) ();
    logic         req0_valid;
    logic         req0_ready;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic [3:0]   req0_aluc;
    logic         req1_valid;
    logic         req1_ready;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic [3:0]   req1_aluc;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [3:0]   alu_aluc;
    logic [W-1:0] alu_r;
    logic [3:0]   alu_flags;
    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [W-1:0] rsp_r;
    logic [3:0]   rsp_flags;
    logic         busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_aluc,
        input  req1_valid, req1_a, req1_b, req1_aluc,
        input  alu_r, alu_flags, rsp_ready,
        output req0_ready, req1_ready,
        output alu_a, alu_b, alu_aluc,
        output rsp_valid, rsp_id, rsp_r, rsp_flags, busy
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_aluc,
        output req1_valid, req1_a, req1_b, req1_aluc,
        output alu_r, alu_flags, rsp_ready,
        input  req0_ready, req1_ready,
        input  alu_a, alu_b, alu_aluc,
        input  rsp_valid, rsp_id, rsp_r, rsp_flags, busy
    );
endinterface
`default_nettype wire

// File: rtl/alu_share_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : alu_share_ctrl
//  Description : Round-robin sharing of one ALU between two requesters.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_share_ctrl #(
    parameter int W           = 32,
    parameter int EXEC_CYCLES = 1
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    alu_share_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [3:0] c_cnt_init = 4'(EXEC_CYCLES - 1);

    state_t       r_state;
    state_t       w_next;
    logic         r_rr_ptr;
    logic [W-1:0] r_a;
    logic [W-1:0] r_b;
    logic [3:0]   r_aluc;
    logic         r_id;
    logic [3:0]   r_cnt;
    logic [W-1:0] r_rsp_r;
    logic [3:0]   r_rsp_flags;

    logic w_idle;
    logic w_grant0;
    logic w_grant1;
    logic w_accept;

    // rr_ptr only matters when both request; a lone requester always wins
    assign w_grant0 = bus.req0_valid & (~bus.req1_valid | ~r_rr_ptr);
    assign w_grant1 = bus.req1_valid & (~bus.req0_valid |  r_rr_ptr);
    assign w_idle   = (r_state == S_IDLE);
    assign w_accept = w_idle & (w_grant0 | w_grant1);

    assign bus.req0_ready = w_idle & w_grant0;
    assign bus.req1_ready = w_idle & w_grant1;

    assign bus.alu_a     = w_idle ? '0 : r_a;
    assign bus.alu_b     = w_idle ? '0 : r_b;
    assign bus.alu_aluc  = w_idle ? '0 : r_aluc;
    assign bus.rsp_valid = (r_state == S_RESP);
    assign bus.rsp_id    = r_id;
    assign bus.rsp_r     = r_rsp_r;
    assign bus.rsp_flags = r_rsp_flags;
    assign bus.busy      = ~w_idle;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)          w_next = S_EXEC;
            S_EXEC:  if (r_cnt == 4'd0)     w_next = S_RESP;
            S_RESP:  if (bus.rsp_ready)     w_next = S_IDLE;
            default:                        w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr    <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_aluc      <= '0;
            r_id        <= 1'b0;
            r_cnt       <= '0;
            r_rsp_r     <= '0;
            r_rsp_flags <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a    <= w_grant1 ? bus.req1_a    : bus.req0_a;
                        r_b    <= w_grant1 ? bus.req1_b    : bus.req0_b;
                        r_aluc <= w_grant1 ? bus.req1_aluc : bus.req0_aluc;
                        r_id   <= w_grant1;
                        r_cnt  <= c_cnt_init;
                    end
                end
                S_EXEC: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_rsp_r     <= bus.alu_r;
                        r_rsp_flags <= bus.alu_flags;
                    end
                end
                S_RESP: begin
                    // the requester just served drops to low priority
                    if (bus.rsp_ready) begin
                        r_rr_ptr <= ~r_id;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
